// File: rtl/lnnae_pkg.sv
// Shared constants and FSM state encoding for the LNN array-engine controller.
// Latency and flow control are defined by lnnae_controller; this file holds only types.
package lnnae_pkg;
  localparam int   LNNAE_N_DEFAULT = 4;
  localparam logic HORIZONTAL      = 1'b0;
  localparam logic VERTICAL        = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LOAD,
    CALC,
    CAPTURE,
    DONE
  } state_t;
endpackage

// File: rtl/lnnae_controller_if.sv
// Host/array-side signal bundle for lnnae_controller; the controller uses the slave modport.
// Rows flow in with a valid/ready pair, and the array strobes and the result flow out.
interface lnnae_controller_if
  import lnnae_pkg::*;
#(
  parameter int N = LNNAE_N_DEFAULT
);
  logic         start;
  logic [N-1:0] row_in;
  logic         row_valid;
  logic         row_ready;
  logic [7:0]   cnot_count;
  logic         loading;
  logic         enable;
  logic         shiftdirection;
  logic [N-1:0] datain;
  logic         busy;
  logic [7:0]   result;
  logic         result_valid;

  modport master (
    output start, row_in, row_valid, cnot_count,
    input  row_ready, loading, enable, shiftdirection, datain, busy, result, result_valid
  );

  modport slave (
    input  start, row_in, row_valid, cnot_count,
    output row_ready, loading, enable, shiftdirection, datain, busy, result, result_valid
  );
endinterface

// File: rtl/lnnae_row_buffer.sv
// N x N row store with one write port and one combinational read port.
// Writes take effect on the clock edge; there is no flow control because the caller owns indexing.
module lnnae_row_buffer
  import lnnae_pkg::*;
#(
  parameter int N = LNNAE_N_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [$clog2(N)-1:0] i_wr_idx,
  input  logic [N-1:0]         i_wr_data,
  input  logic [$clog2(N)-1:0] i_rd_idx,
  output logic [N-1:0]         o_rd_data
);
  logic [N-1:0] r_mem [N];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
endmodule

// File: rtl/lnnae_controller.sv
// Sequences row collection, array load, 2(N-1)^2 compute cycles and CNOT-count capture.
// Result appears 2N+2(N-1)^2+2 cycles after start with back-to-back rows; row gaps stall COLLECT.
module lnnae_controller
  import lnnae_pkg::*;
#(
  parameter int N = LNNAE_N_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  lnnae_controller_if.slave bus
);
  localparam int             IW        = $clog2(N);
  localparam int             PW        = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [IW-1:0]  LAST_ROW  = IW'(N - 1);
  localparam logic [PW-1:0]  LAST_STEP = PW'(N - 2);

  state_t        r_state;
  logic [IW-1:0] r_wr_idx;
  logic [IW-1:0] r_ld_idx;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_pass;
  logic          r_row_ready;
  logic          r_loading;
  logic          r_enable;
  logic          r_dir;
  logic          r_busy;
  logic          r_result_valid;
  logic [N-1:0]  r_datain;
  logic [7:0]    r_result;

  logic          w_wr_en;
  logic [IW-1:0] w_rd_idx;
  logic [N-1:0]  w_rd_data;

  assign w_wr_en = (r_state == COLLECT) && r_row_ready && bus.row_valid;
  // datain is registered, so the buffer is read one slot ahead of the row currently on datain.
  assign w_rd_idx = (r_state == LOAD && r_ld_idx != LAST_ROW) ? r_ld_idx + 1'b1 : '0;

  lnnae_row_buffer #(.N(N)) u_row_buffer (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_wr_idx),
    .i_wr_data (bus.row_in),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wr_idx       <= '0;
      r_ld_idx       <= '0;
      r_phase        <= '0;
      r_pass         <= '0;
      r_row_ready    <= 1'b0;
      r_loading      <= 1'b0;
      r_enable       <= 1'b0;
      r_dir          <= VERTICAL;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_datain       <= '0;
      r_result       <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state     <= COLLECT;
          r_busy      <= 1'b1;
          r_row_ready <= 1'b1;
          r_wr_idx    <= '0;
        end
        COLLECT: if (w_wr_en) begin
          if (r_wr_idx == LAST_ROW) begin
            r_state     <= LOAD;
            r_row_ready <= 1'b0;
            r_loading   <= 1'b1;
            r_datain    <= w_rd_data;
            r_ld_idx    <= '0;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
        LOAD: if (r_ld_idx == LAST_ROW) begin
          r_state   <= CALC;
          r_loading <= 1'b0;
          r_datain  <= '0;
          r_enable  <= 1'b1;
          r_dir     <= VERTICAL;
          r_phase   <= '0;
          r_pass    <= '0;
        end else begin
          r_ld_idx <= r_ld_idx + 1'b1;
          r_datain <= w_rd_data;
        end
        CALC: if (r_phase != LAST_STEP) begin
          r_phase <= r_phase + 1'b1;
        end else begin
          r_phase <= '0;
          if (r_dir == VERTICAL) begin
            r_dir <= HORIZONTAL;
          end else if (r_pass == LAST_STEP) begin
            r_state  <= CAPTURE;
            r_enable <= 1'b0;
            r_dir    <= VERTICAL;
          end else begin
            r_pass <= r_pass + 1'b1;
            r_dir  <= VERTICAL;
          end
        end
        CAPTURE: begin
          r_result       <= bus.cnot_count;
          r_result_valid <= 1'b1;
          r_state        <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.row_ready      = r_row_ready;
  assign bus.loading        = r_loading;
  assign bus.enable         = r_enable;
  assign bus.shiftdirection = r_dir;
  assign bus.datain         = r_datain;
  assign bus.busy           = r_busy;
  assign bus.result         = r_result;
  assign bus.result_valid   = r_result_valid;
endmodule

// File: tb/tb_lnnae_controller.sv
// Randomised bench for lnnae_controller; expected traces come from cycle-window arithmetic.
module tb_lnnae_controller;
  import lnnae_pkg::*;

  localparam int N  = 4;
  localparam int VW = 14 + N;

  logic clock;
  logic reset;

  lnnae_controller_if #(.N(N)) bus ();

  lnnae_controller #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]  tb_rows [N];
  int            tb_gaps [N];
  logic [VW-1:0] obs_vec [0:79];
  logic [7:0]    drv_cnot [0:79];
  logic [7:0]    last_res;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // {loading, enable, dir, datain (only meaningful while loading), row_ready, busy, result_valid, result}
  function automatic logic [VW-1:0] sample_outputs();
    return {bus.loading, bus.enable, bus.shiftdirection, bus.loading ? bus.datain : {N{1'b0}},
            bus.row_ready, bus.busy, bus.result_valid, bus.result};
  endfunction

  function automatic int last_accept();
    int a;
    a = N;
    for (int i = 0; i < N; i++) a += tb_gaps[i];
    return a;
  endfunction

  function automatic int done_cycle();
    return last_accept() + N + 2 * (N - 1) * (N - 1) + 2;
  endfunction

  // Expected outputs in cycle k, where cycle k ends at the k-th edge after the start-sampling edge.
  function automatic logic [VW-1:0] expect_at(input int k, input logic [7:0] prev, input logic [7:0] res);
    int a, c0, t;
    logic ld, en, dir;
    logic [N-1:0] din;
    a   = last_accept();
    c0  = a + N + 1;
    t   = done_cycle();
    ld  = (k > a) && (k <= a + N);
    en  = (k >= c0) && (k < c0 + 2 * (N - 1) * (N - 1));
    dir = VERTICAL;
    din = '0;
    if (ld) din = tb_rows[k - a - 1];
    if (en && ((k - c0) % (2 * (N - 1))) >= N - 1) dir = HORIZONTAL;
    return {ld, en, dir, din, (k >= 1 && k <= a), (k >= 1 && k <= t), (k == t), (k >= t) ? res : prev};
  endfunction

  task automatic drive_run(input int ncyc, input int start_at, input bit idle_rv,
                           input bit rnd_cnot, input logic [7:0] cnot);
    int ptr;
    int wait_cnt;
    ptr      = 0;
    wait_cnt = tb_gaps[0];
    @(negedge clock);
    obs_vec[0]     = sample_outputs();
    drv_cnot[0]    = rnd_cnot ? 8'($urandom) : cnot;
    bus.cnot_count = drv_cnot[0];
    bus.start      = 1'b1;
    bus.row_valid  = idle_rv;
    bus.row_in     = ~tb_rows[0];
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      obs_vec[k]     = sample_outputs();
      bus.start      = (k == start_at);
      drv_cnot[k]    = rnd_cnot ? 8'($urandom) : cnot;
      bus.cnot_count = drv_cnot[k];
      if (ptr < N && wait_cnt == 0) begin
        bus.row_valid = 1'b1;
        bus.row_in    = tb_rows[ptr];
      end else begin
        bus.row_valid = (ptr >= N) ? 1'($urandom) : 1'b0;
        bus.row_in    = N'($urandom);
        if (ptr < N) wait_cnt--;
      end
      if (ptr < N && bus.row_valid && bus.row_ready) begin
        ptr++;
        if (ptr < N) wait_cnt = tb_gaps[ptr];
      end
    end
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] idle_vec;
    idle_vec       = {1'b0, 1'b0, VERTICAL, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 8'h00};
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.row_valid  = 1'b0;
    bus.row_in     = '0;
    bus.cnot_count = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (sample_outputs() !== idle_vec) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", sample_outputs(), idle_vec);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (sample_outputs() !== idle_vec) begin
      failures++;
      $display("FAIL reset_released got=%h exp=%h", sample_outputs(), idle_vec);
    end
    last_res = 8'h00;
  endtask

  task automatic test_basic();
    int t;
    tb_rows[0] = 4'd8; tb_rows[1] = 4'd4; tb_rows[2] = 4'd2; tb_rows[3] = 4'd1;
    for (int i = 0; i < N; i++) tb_gaps[i] = 0;
    t = done_cycle();
    drive_run(t + 3, -1, 1'b0, 1'b0, 8'd13);
    for (int k = 0; k <= t + 3; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, 8'd13)) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, 8'd13));
      end
    end
    last_res = 8'd13;
  endtask

  task automatic test_gaps();
    int t;
    logic [7:0] c;
    c = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      tb_rows[i] = N'($urandom);
      tb_gaps[i] = (i == 1) ? 2 : 0;
    end
    t = done_cycle();
    drive_run(t + 3, -1, 1'b0, 1'b0, c);
    for (int k = 0; k <= t + 3; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, c)) begin
        failures++;
        $display("FAIL gaps cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, c));
      end
    end
    checks++;
    if (obs_vec[30][8] !== 1'b1) begin
      failures++;
      $display("FAIL gaps_rv_cycle30 got=%b exp=1", obs_vec[30][8]);
    end
    last_res = c;
  endtask

  task automatic test_start_in_calc();
    int t;
    int falls;
    logic [7:0] c;
    c = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      tb_rows[i] = N'($urandom);
      tb_gaps[i] = 0;
    end
    t = done_cycle();
    drive_run(t + 6, 12, 1'b0, 1'b0, c);
    falls = 0;
    for (int k = 0; k <= t + 6; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, c)) begin
        failures++;
        $display("FAIL start_in_calc cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, c));
      end
      if (k > 0 && obs_vec[k-1][9] && !obs_vec[k][9]) falls++;
    end
    checks++;
    if (falls !== 1) begin
      failures++;
      $display("FAIL busy_falls got=%0d exp=1", falls);
    end
    last_res = c;
  endtask

  task automatic test_reset_mid_calc();
    int t;
    logic [VW-1:0] idle_vec;
    idle_vec = {1'b0, 1'b0, VERTICAL, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < N; i++) begin
      tb_rows[i] = N'($urandom);
      tb_gaps[i] = 0;
    end
    drive_run(18, -1, 1'b0, 1'b0, 8'd77);
    for (int k = 0; k <= 18; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, 8'd77)) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, 8'd77));
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (sample_outputs() !== idle_vec) begin
      failures++;
      $display("FAIL reset_in_calc got=%h exp=%h", sample_outputs(), idle_vec);
    end
    @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    last_res = 8'h00;
    for (int i = 0; i < N; i++) tb_rows[i] = N'($urandom);
    t = done_cycle();
    drive_run(t + 3, -1, 1'b0, 1'b0, 8'h5A);
    for (int k = 0; k <= t + 3; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, 8'h5A)) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, 8'h5A));
      end
    end
    last_res = 8'h5A;
  endtask

  task automatic test_ff_idle_row();
    int t;
    for (int i = 0; i < N; i++) begin
      tb_rows[i] = N'($urandom);
      tb_gaps[i] = 0;
    end
    t = done_cycle();
    drive_run(t + 3, -1, 1'b1, 1'b0, 8'hFF);
    for (int k = 0; k <= t + 3; k++) begin
      checks++;
      if (obs_vec[k] !== expect_at(k, last_res, 8'hFF)) begin
        failures++;
        $display("FAIL ff_idle_row cyc=%0d got=%h exp=%h", k, obs_vec[k], expect_at(k, last_res, 8'hFF));
      end
    end
    last_res = 8'hFF;
  endtask

  task automatic test_random();
    int t;
    int st;
    logic [7:0] res;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        tb_rows[i] = N'($urandom);
        tb_gaps[i] = $urandom_range(0, 3);
      end
      t  = done_cycle();
      st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, t) : -1;
      drive_run(t + 2, st, 1'($urandom), 1'b1, 8'h00);
      res = drv_cnot[t - 1];
      for (int k = 0; k <= t + 2; k++) begin
        checks++;
        if (obs_vec[k] !== expect_at(k, last_res, res)) begin
          failures++;
          $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", r, k, obs_vec[k], expect_at(k, last_res, res));
        end
      end
      last_res = res;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_start_in_calc();
    test_reset_mid_calc();
    test_ff_idle_row();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
